dca_engine: RTL and testbench
=============================

// Module: dca_engine
// PURPOSE
//  Direct-cache-access engine at the far end of the core's DCA request port. It accepts one
//  {cmd, addr, len} job at a time and moves whole 256-bit cache lines over the D-cache DCA port.
//  Lines flow between the NIC line streams and the D-cache in either direction: NIC->cache (write)
//  or cache->NIC (read). It sits beside aquila_top and drives the dcache n_dca_* pins.
// PARAMETERS
//  XLEN     32   address/length width
//  CLSIZE   256  cache line width in bits (32 bytes per line)
// PORTS
//  clk_i            in   1       system clock
//  rst_i            in   1       synchronous, active-high reset
//  dca_req_i        in   1       job request from core
//  dca_ready_o      out  1       engine idle; a job is accepted on req&ready
//  dca_cmd_i        in   2       00 NOP, 01 WRITE (NIC->cache), 10 READ (cache->NIC), 11 reserved
//  dca_addr_i       in   XLEN    start byte address; bits[4:0] are ignored
//  dca_len_i        in   XLEN    length in bytes
//  dca_done_o       out  1       one-cycle pulse when the job completes
//  c_addr_o         out  XLEN    line address to D-cache (bits[4:0]=0)
//  c_data_o         out  CLSIZE  write line to D-cache
//  c_data_i         in   CLSIZE  read line from D-cache, valid when c_ready_i=1
//  c_strobe_o       out  1       D-cache access request
//  c_we_o           out  1       1=write, 0=read
//  c_ready_i        in   1       D-cache access complete (1-cycle pulse)
//  rx_valid_i       in   1       NIC line available for a WRITE job
//  rx_data_i        in   CLSIZE  NIC line
//  rx_ready_o       out  1       line consumed when rx_valid_i&rx_ready_o
//  tx_valid_o       out  1       line available to the NIC for a READ job
//  tx_data_o        out  CLSIZE  line to the NIC
//  tx_ready_i       in   1       NIC takes the line when tx_valid_o&tx_ready_i
// BEHAVIOUR
//  Reset values: dca_ready_o=1; dca_done_o, c_strobe_o, c_we_o, rx_ready_o, tx_valid_o all 0;
//   c_addr_o, c_data_o, tx_data_o all 0; state IDLE; counters 0.
//  Accept: in IDLE, req&ready latches the job.
//   - line_addr = {addr[31:5], 5'b0}
//   - nlines = (len+31)>>5, computed at 33-bit width so len=0xFFFF_FFFF does not overflow
//   - dca_ready_o drops in the next cycle and stays low until the cycle after dca_done_o
//  NOP, reserved cmd, or nlines==0: state DONE in the next cycle, then dca_done_o=1 for 1 cycle,
//   then IDLE. No cache or stream activity occurs.
//  States: IDLE, WR_GET, WR_ISSUE, RD_ISSUE, RD_PUSH, DONE.
//  WR_GET: rx_ready_o=1. On an rx handshake, latch rx_data_i into c_data_o and go to WR_ISSUE.
//  WR_ISSUE: c_strobe_o=1, c_we_o=1. addr and data are held stable until c_ready_i.
//   On c_ready_i: strobe drops in the next cycle; line_addr += 32; remaining -= 1.
//   Next state is DONE if remaining hits 0, else WR_GET.
//  RD_ISSUE: c_strobe_o=1, c_we_o=0, addr held stable.
//   On c_ready_i: latch c_data_i into tx_data_o and go to RD_PUSH.
//  RD_PUSH: tx_valid_o=1 with tx_data_o held stable until tx_ready_i.
//   On the handshake: line_addr += 32; remaining -= 1; next state DONE or RD_ISSUE.
//  No back-to-back strobes: c_strobe_o is low for at least 1 cycle between accesses.
//  Minimum latency per line: WRITE 2 cycles + cache latency; READ 2 cycles + cache latency.
//  line_addr wraps modulo 2^32 (0xFFFF_FFE0 + 32 -> 0x0000_0000) with no error.
//  dca_req_i while busy is ignored; request signals are sampled only at accept.
//  rst_i mid-job: the job is abandoned. The next cycle shows reset values: strobe, tx_valid and
//   rx_ready low. Any in-flight cache response is ignored.
//  Simultaneous c_ready_i and rst_i: reset wins.
// TESTING
//  1. WRITE, addr=0x8000_0040, len=64, two rx lines A,B ->
//     strobes at 0x8000_0040 (data A) and 0x8000_0060 (data B), both with we=1; one done pulse.
//  2. READ, addr=0x8000_0047, len=33, cache returns L0,L1 ->
//     accesses at 0x8000_0040 and 0x8000_0060 with we=0; tx gets L0 then L1; done.
//  3. READ with tx_ready_i held low 10 cycles ->
//     tx_valid_o/tx_data_o stable; no new c_strobe_o until the handshake.
//  4. len=0 and cmd=11 -> dca_done_o 2 cycles after accept; c_strobe_o never asserted.
//  5. rst_i during WR_ISSUE of line 2 of 4 ->
//     the next cycle shows ready=1, strobe=0; a new READ job runs correctly afterwards.
//  6. WRITE, addr=0xFFFF_FFE0, len=64 -> line addresses 0xFFFF_FFE0 then 0x0000_0000.

Source files
------------

// File: rtl/dca_engine.sv
// Direct-cache-access engine: moves whole cache lines between the NIC line streams
// and the D-cache DCA port, one {cmd, addr, len} job at a time.
module dca_engine #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CLSIZE = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dca_req_i,
    output logic              dca_ready_o,
    input  logic [1:0]        dca_cmd_i,
    input  logic [XLEN-1:0]   dca_addr_i,
    input  logic [XLEN-1:0]   dca_len_i,
    output logic              dca_done_o,
    output logic [XLEN-1:0]   c_addr_o,
    output logic [CLSIZE-1:0] c_data_o,
    input  logic [CLSIZE-1:0] c_data_i,
    output logic              c_strobe_o,
    output logic              c_we_o,
    input  logic              c_ready_i,
    input  logic              rx_valid_i,
    input  logic [CLSIZE-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic              tx_valid_o,
    output logic [CLSIZE-1:0] tx_data_o,
    input  logic              tx_ready_i
);

    localparam int unsigned LINE_BYTES = CLSIZE / 8;
    localparam int unsigned OFS_W      = $clog2(LINE_BYTES);
    localparam int unsigned CNT_W      = XLEN + 1 - OFS_W;

    localparam logic [1:0]      CMD_WRITE = 2'b01;
    localparam logic [1:0]      CMD_READ  = 2'b10;
    localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(LINE_BYTES - 1);
    localparam logic [XLEN-1:0] LINE_STEP = XLEN'(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WR_GET,
        WR_ISSUE,
        RD_ISSUE,
        RD_PUSH,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;

    // Line count rounded up, one bit wider than len so an all-ones length cannot wrap.
    logic [XLEN:0]    len_sum_c;
    logic [CNT_W-1:0] nlines_c;

    assign len_sum_c = {1'b0, dca_len_i} + (XLEN+1)'(LINE_BYTES - 1);
    assign nlines_c  = CNT_W'(len_sum_c >> OFS_W);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            remaining   <= '0;
            dca_ready_o <= 1'b1;
            dca_done_o  <= 1'b0;
            c_addr_o    <= '0;
            c_data_o    <= '0;
            c_strobe_o  <= 1'b0;
            c_we_o      <= 1'b0;
            rx_ready_o  <= 1'b0;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= '0;
        end else begin
            dca_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Ready returns one cycle after the done pulse.
                    dca_ready_o <= 1'b1;
                    if (dca_req_i && dca_ready_o) begin
                        dca_ready_o <= 1'b0;
                        c_addr_o    <= dca_addr_i & LINE_MASK;
                        remaining   <= nlines_c;
                        if (nlines_c == '0) begin
                            state <= DONE;
                        end else if (dca_cmd_i == CMD_WRITE) begin
                            rx_ready_o <= 1'b1;
                            state      <= WR_GET;
                        end else if (dca_cmd_i == CMD_READ) begin
                            c_strobe_o <= 1'b1;
                            c_we_o     <= 1'b0;
                            state      <= RD_ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WR_GET: begin
                    if (rx_valid_i) begin
                        rx_ready_o <= 1'b0;
                        c_data_o   <= rx_data_i;
                        c_strobe_o <= 1'b1;
                        c_we_o     <= 1'b1;
                        state      <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (c_ready_i) begin
                        c_strobe_o <= 1'b0;
                        c_we_o     <= 1'b0;
                        c_addr_o   <= c_addr_o + LINE_STEP;
                        remaining  <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            rx_ready_o <= 1'b1;
                            state      <= WR_GET;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (c_ready_i) begin
                        c_strobe_o <= 1'b0;
                        tx_data_o  <= c_data_i;
                        tx_valid_o <= 1'b1;
                        state      <= RD_PUSH;
                    end
                end
                RD_PUSH: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        c_addr_o   <= c_addr_o + LINE_STEP;
                        remaining  <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            c_strobe_o <= 1'b1;
                            c_we_o     <= 1'b0;
                            state      <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    dca_done_o <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dca_engine.sv
// Randomized self-checking bench for dca_engine: the bench plays core, D-cache and NIC,
// and checks every access, line and pulse against job-level expectations.
module tb_dca_engine;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CLSIZE = 256;
    localparam int          BUDGET = 3000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              dca_req_i;
    logic              dca_ready_o;
    logic [1:0]        dca_cmd_i;
    logic [XLEN-1:0]   dca_addr_i;
    logic [XLEN-1:0]   dca_len_i;
    logic              dca_done_o;
    logic [XLEN-1:0]   c_addr_o;
    logic [CLSIZE-1:0] c_data_o;
    logic [CLSIZE-1:0] c_data_i;
    logic              c_strobe_o;
    logic              c_we_o;
    logic              c_ready_i;
    logic              rx_valid_i;
    logic [CLSIZE-1:0] rx_data_i;
    logic              rx_ready_o;
    logic              tx_valid_o;
    logic [CLSIZE-1:0] tx_data_o;
    logic              tx_ready_i;

    int checks = 0;
    int errors = 0;

    dca_engine #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dca_req_i   (dca_req_i),
        .dca_ready_o (dca_ready_o),
        .dca_cmd_i   (dca_cmd_i),
        .dca_addr_i  (dca_addr_i),
        .dca_len_i   (dca_len_i),
        .dca_done_o  (dca_done_o),
        .c_addr_o    (c_addr_o),
        .c_data_o    (c_data_o),
        .c_data_i    (c_data_i),
        .c_strobe_o  (c_strobe_o),
        .c_we_o      (c_we_o),
        .c_ready_i   (c_ready_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [CLSIZE-1:0] obs, input logic [CLSIZE-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CLSIZE-1:0] rand_line();
        logic [CLSIZE-1:0] l;
        for (int i = 0; i < CLSIZE / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},  dca_ready_o, 1);
        check_eq({tag, "_done"},   dca_done_o, 0);
        check_eq({tag, "_strobe"}, c_strobe_o, 0);
        check_eq({tag, "_rx_rdy"}, rx_ready_o, 0);
        check_eq({tag, "_tx_vld"}, tx_valid_o, 0);
    endtask

    // One job end to end; abort_line >= 0 fires a reset (with a colliding c_ready) on that access.
    task automatic run_job(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] len,
                           input int hold, input int abort_line);
        logic [32:0]       nl33;
        int                nl;
        bit                active;
        logic [31:0]       base;
        logic [31:0]       exp_addr;
        logic [CLSIZE-1:0] wr_q[$];
        logic [CLSIZE-1:0] rd_q[$];
        int                acc = 0;
        int                txn = 0;
        int                lat = 0;
        int                want_lat;
        int                cyc = 0;
        int                done_cyc = -1;
        int                hold_left = hold;
        bit                resp_prev;

        nl33     = ({1'b0, len} + 33'd31) >> 5;
        nl       = int'(nl33);
        base     = {addr[31:5], 5'b0};
        active   = (cmd == 2'b01 || cmd == 2'b10) && nl != 0;
        want_lat = int'($urandom_range(0, 3));

        for (int i = 0; i < 100 && !dca_ready_o; i++) step();
        check_eq("ready_before_req", dca_ready_o, 1);
        dca_req_i  = 1'b1;
        dca_cmd_i  = cmd;
        dca_addr_i = addr;
        dca_len_i  = len;
        step();

        while (done_cyc < 0 && cyc < BUDGET) begin
            cyc++;
            check_eq("ready_busy", dca_ready_o, 0);
            resp_prev = c_ready_i;
            c_ready_i = 1'b0;

            // Busy-time requests must be ignored.
            dca_req_i  = 1'($urandom % 2);
            dca_cmd_i  = 2'($urandom);
            dca_addr_i = $urandom;
            dca_len_i  = $urandom;

            if (c_strobe_o) begin
                check_eq("strobe_gap", resp_prev, 0);
                if (!active || acc >= nl) begin
                    check_eq("spurious_strobe", c_strobe_o, 0);
                end else begin
                    exp_addr = base + 32'(32 * acc);
                    check_eq("c_addr", c_addr_o, exp_addr);
                    check_eq("c_we", c_we_o, cmd == 2'b01);
                    if (cmd == 2'b01) begin
                        check_eq("wr_line_avail", wr_q.size() > acc, 1);
                        if (wr_q.size() > acc) check_eq("c_data", c_data_o, wr_q[acc]);
                    end
                    if (acc == abort_line) begin
                        rst_i     = 1'b1;
                        c_ready_i = 1'b1;
                        dca_req_i = 1'b0;
                        step();
                        rst_i      = 1'b0;
                        c_ready_i  = 1'b0;
                        rx_valid_i = 1'b0;
                        tx_ready_i = 1'b0;
                        check_reset_outputs("abort");
                        return;
                    end
                    if (lat >= want_lat) begin
                        c_ready_i = 1'b1;
                        c_data_i  = rand_line();
                        if (cmd == 2'b10) rd_q.push_back(c_data_i);
                        acc++;
                        lat      = 0;
                        want_lat = int'($urandom_range(0, 3));
                    end else begin
                        lat++;
                    end
                end
            end

            rx_valid_i = (cmd == 2'b01) && ($urandom % 4 != 0);
            if (rx_valid_i && rx_ready_o) begin
                rx_data_i = rand_line();
                wr_q.push_back(rx_data_i);
            end

            if (tx_valid_o) begin
                check_eq("strobe_in_push", c_strobe_o, 0);
                check_eq("tx_line_avail", rd_q.size() > txn, 1);
                if (rd_q.size() > txn) check_eq("tx_data", tx_data_o, rd_q[txn]);
                if (hold_left > 0) begin
                    tx_ready_i = 1'b0;
                    hold_left--;
                end else begin
                    tx_ready_i = 1'($urandom % 2);
                end
                if (tx_ready_i) txn++;
            end else begin
                tx_ready_i = 1'($urandom % 2);
            end

            if (dca_done_o) begin
                done_cyc   = cyc;
                dca_req_i  = 1'b0;
                rx_valid_i = 1'b0;
                tx_ready_i = 1'b0;
            end
            step();
        end

        check_eq("done_seen", done_cyc >= 0, 1);
        if (!active) check_eq("zero_job_latency", 32'(done_cyc), 2);
        check_eq("access_count", 32'(acc), active ? 32'(nl) : 32'd0);
        if (cmd == 2'b10 && active) check_eq("tx_count", 32'(txn), 32'(nl));
        check_eq("done_pulse", dca_done_o, 0);
        check_eq("ready_after_done", dca_ready_o, 1);
    endtask

    initial begin
        rst_i      = 1'b1;
        dca_req_i  = 1'b0;
        dca_cmd_i  = '0;
        dca_addr_i = '0;
        dca_len_i  = '0;
        c_data_i   = '0;
        c_ready_i  = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        tx_ready_i = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        check_eq("reset_c_addr", c_addr_o, 0);
        check_eq("reset_c_data", c_data_o, 0);
        check_eq("reset_tx_data", tx_data_o, 0);
        check_eq("reset_c_we", c_we_o, 0);
        rst_i = 1'b0;
        step();

        run_job(2'b01, 32'h8000_0040, 32'd64, 0, -1);
        run_job(2'b10, 32'h8000_0047, 32'd33, 0, -1);
        run_job(2'b10, 32'h1234_5600, 32'd96, 10, -1);
        run_job(2'b01, 32'h0000_1000, 32'd0, 0, -1);
        run_job(2'b11, 32'h0000_2000, 32'd64, 0, -1);
        run_job(2'b00, 32'h0000_3000, 32'd64, 0, -1);
        run_job(2'b01, 32'h4000_0000, 32'd128, 0, 1);
        run_job(2'b10, 32'h4000_0020, 32'd70, 0, -1);
        run_job(2'b01, 32'hFFFF_FFE0, 32'd64, 0, -1);
        run_job(2'b10, 32'hFFFF_FFC5, 32'd100, 0, -1);

        for (int j = 0; j < 25; j++) begin
            run_job(2'($urandom), $urandom, 32'($urandom_range(0, 200)),
                    int'($urandom_range(0, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
